// File: rtl/dvp_cam_pwr_seq_pkg.sv
// Shared definitions for the DVP camera power sequencer: state encoding,
// camera-config bit positions and small helpers used by the FSM.
package dvp_cam_pkg;

  localparam int STATE_W = 3;

  // Status readback encoding; software decodes state_o with these values.
  typedef enum logic [STATE_W-1:0] {
    ST_IDLE      = 3'd0,
    ST_PWDN_HOLD = 3'd1,
    ST_SETTLE    = 3'd2,
    ST_READY     = 3'd3,
    ST_SHUTDOWN  = 3'd4
  } seq_state_e;

  // Bit positions inside the config word; the camera controller uses the same ones.
  localparam int CFG_START_BIT = 0;
  localparam int CFG_PWDN_BIT  = 1;

  // Pin-level view of what the camera sees in a given state.
  typedef struct packed {
    logic start;
    logic pwdn;
  } cam_ctl_t;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // XCLK runs in every state except IDLE; PWDN is held except while settling/ready.
  function automatic cam_ctl_t state_ctl(input seq_state_e s);
    cam_ctl_t c;
    c.start = 1'b0;
    c.pwdn  = 1'b1;
    case (s)
      ST_IDLE:      begin c.start = 1'b0; c.pwdn = 1'b1; end
      ST_PWDN_HOLD: begin c.start = 1'b1; c.pwdn = 1'b1; end
      ST_SETTLE:    begin c.start = 1'b1; c.pwdn = 1'b0; end
      ST_READY:     begin c.start = 1'b1; c.pwdn = 1'b0; end
      ST_SHUTDOWN:  begin c.start = 1'b1; c.pwdn = 1'b1; end
      default:      begin c.start = 1'b0; c.pwdn = 1'b1; end
    endcase
    return c;
  endfunction

endpackage

// File: rtl/dvp_cam_pwr_seq_if.sv
// Request/status bundle between the power sequencer and its controller.
interface dvp_cam_pwr_seq_if #(
  parameter int DVP_CAM_CFG_W = 32
) ();
  import dvp_cam_pkg::*;

  logic                     pwr_up_req_i;
  logic                     pwr_dn_req_i;
  logic [DVP_CAM_CFG_W-1:0] dcr_cam_cfg_o;
  logic                     cam_ready_o;
  logic                     busy_o;
  logic                     done_o;
  logic [STATE_W-1:0]       state_o;

  // Controller side: issues requests, observes status.
  modport master (
    output pwr_up_req_i, pwr_dn_req_i,
    input  dcr_cam_cfg_o, cam_ready_o, busy_o, done_o, state_o
  );

  // Sequencer side.
  modport slave (
    input  pwr_up_req_i, pwr_dn_req_i,
    output dcr_cam_cfg_o, cam_ready_o, busy_o, done_o, state_o
  );
endinterface

// File: rtl/dvp_cam_pwr_seq_timer.sv
// Loadable down-counter with zero flag; saturates at 0 so it never wraps.
module dvp_seq_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] cnt,
  output logic         zero
);

  // Load has priority; otherwise count down and park at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          cnt <= '0;
    else if (load)       cnt <= load_val;
    else if (cnt != '0)  cnt <= cnt - W'(1);
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/dvp_cam_pwr_seq.sv
// DVP camera power sequencer: PWDN hold with XCLK running, release and settle,
// then READY; orderly shutdown on request, abortable mid power-up.
module dvp_cam_pwr_seq
  import dvp_cam_pkg::*;
#(
  parameter int DVP_CAM_CFG_W = 32,
  parameter int PWDN_HOLD_CYC = 125000,
  parameter int SETTLE_CYC    = 1250000
) (
  input  logic               clk,
  input  logic               rst_n,
  dvp_cam_pwr_seq_if.slave   bus
);

  localparam int TMR_W = $clog2(max2(PWDN_HOLD_CYC, SETTLE_CYC) + 1);
  localparam logic [TMR_W-1:0] HOLD_LD   = TMR_W'(PWDN_HOLD_CYC - 1);
  localparam logic [TMR_W-1:0] SETTLE_LD = TMR_W'(SETTLE_CYC - 1);

  seq_state_e       st, nxt;
  logic             tmr_load;
  logic [TMR_W-1:0] tmr_val;
  logic [TMR_W-1:0] tmr_cnt;
  logic             tmr_zero;
  logic             done_d, done_q;
  logic             up_req, dn_req;
  cam_ctl_t         ctl;

  // A simultaneous down request cancels an up request.
  assign dn_req = bus.pwr_dn_req_i;
  assign up_req = bus.pwr_up_req_i & ~bus.pwr_dn_req_i;

  dvp_seq_timer #(.W(TMR_W)) u_tmr (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .cnt      (tmr_cnt),
    .zero     (tmr_zero)
  );

  // State register plus registered done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st     <= ST_IDLE;
      done_q <= 1'b0;
    end else begin
      st     <= nxt;
      done_q <= done_d;
    end
  end

  // Next state and timer loads; a timed state leaves on the edge where the timer reads 0.
  always_comb begin
    nxt      = st;
    tmr_load = 1'b0;
    tmr_val  = '0;
    case (st)
      ST_IDLE: begin
        if (up_req) begin
          nxt      = ST_PWDN_HOLD;
          tmr_load = 1'b1;
          tmr_val  = HOLD_LD;
        end
      end
      ST_PWDN_HOLD: begin
        if (dn_req) begin
          nxt      = ST_SHUTDOWN;
          tmr_load = 1'b1;
          tmr_val  = HOLD_LD;
        end else if (tmr_zero) begin
          nxt      = ST_SETTLE;
          tmr_load = 1'b1;
          tmr_val  = SETTLE_LD;
        end
      end
      ST_SETTLE: begin
        if (dn_req) begin
          nxt      = ST_SHUTDOWN;
          tmr_load = 1'b1;
          tmr_val  = HOLD_LD;
        end else if (tmr_zero) begin
          nxt = ST_READY;
        end
      end
      ST_READY: begin
        if (dn_req) begin
          nxt      = ST_SHUTDOWN;
          tmr_load = 1'b1;
          tmr_val  = HOLD_LD;
        end
      end
      ST_SHUTDOWN: begin
        if (tmr_zero) nxt = ST_IDLE;
      end
      default: nxt = ST_IDLE;
    endcase
  end

  // Outputs decoded from the registered state; done is flagged one edge early and registered.
  always_comb begin
    done_d = ((st == ST_SETTLE)   && (nxt == ST_READY)) ||
             ((st == ST_SHUTDOWN) && (nxt == ST_IDLE));
    ctl = state_ctl(st);
    bus.dcr_cam_cfg_o                = '0;
    bus.dcr_cam_cfg_o[CFG_START_BIT] = ctl.start;
    bus.dcr_cam_cfg_o[CFG_PWDN_BIT]  = ctl.pwdn;
    bus.cam_ready_o = (st == ST_READY);
    bus.busy_o      = (st == ST_PWDN_HOLD) || (st == ST_SETTLE) || (st == ST_SHUTDOWN);
    bus.done_o      = done_q;
    bus.state_o     = st;
  end

endmodule

// File: tb/tb_dvp_cam_pwr_seq.sv
// Bench for dvp_cam_pwr_seq with short timings (hold 4, settle 8).
module tb_dvp_cam_pwr_seq;

  localparam int H = 4;
  localparam int S = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dvp_cam_pwr_seq_if #(.DVP_CAM_CFG_W(32)) bus ();

  dvp_cam_pwr_seq #(
    .DVP_CAM_CFG_W (32),
    .PWDN_HOLD_CYC (H),
    .SETTLE_CYC    (S)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: phase 0=off, 1=powering up, 2=on, 3=powering down; t = cycles spent in phase (1 = first).
  int m_ph   = 0;
  int m_t    = 0;
  bit m_done = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ph   <= 0;
      m_t    <= 0;
      m_done <= 1'b0;
    end else begin : upd
      int ph, t;
      bit d, up, dn;
      up = bus.pwr_up_req_i;
      dn = bus.pwr_dn_req_i;
      ph = m_ph; t = m_t; d = 1'b0;
      case (m_ph)
        0: if (up && !dn) begin ph = 1; t = 1; end
        1: begin
          if (dn) begin ph = 3; t = 1; end
          else begin
            t = t + 1;
            if (t > H + S) begin ph = 2; t = 0; d = 1'b1; end
          end
        end
        2: if (dn) begin ph = 3; t = 1; end
        default: begin
          t = t + 1;
          if (t > H) begin ph = 0; t = 0; d = 1'b1; end
        end
      endcase
      m_ph   <= ph;
      m_t    <= t;
      m_done <= d;
    end
  end

  function automatic int exp_state(input int ph, input int t);
    case (ph)
      0: return 0;
      1: return (t <= H) ? 1 : 2;
      2: return 3;
      default: return 4;
    endcase
  endfunction

  function automatic int exp_cfg(input int ph, input int t);
    case (ph)
      0: return 2;
      1: return (t <= H) ? 3 : 1;
      2: return 1;
      default: return 3;
    endcase
  endfunction

  int ready_cnt = 0;

  // Every-cycle comparison against the model, sampled mid-cycle.
  always @(negedge clk) begin
    chk("mdl_state", 32'(bus.state_o), 32'(exp_state(m_ph, m_t)));
    chk("mdl_cfg",   bus.dcr_cam_cfg_o, 32'(exp_cfg(m_ph, m_t)));
    chk("mdl_ready", 32'(bus.cam_ready_o), 32'(m_ph == 2));
    chk("mdl_busy",  32'(bus.busy_o), 32'(m_ph == 1 || m_ph == 3));
    chk("mdl_done",  32'(bus.done_o), 32'(m_done));
    if (bus.cam_ready_o) ready_cnt++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input bit up, input bit dn);
    bus.pwr_up_req_i = up;
    bus.pwr_dn_req_i = dn;
    step();
    bus.pwr_up_req_i = 1'b0;
    bus.pwr_dn_req_i = 1'b0;
  endtask

  initial begin
    int r0;
    bus.pwr_up_req_i = 1'b0;
    bus.pwr_dn_req_i = 1'b0;
    rst_n = 1'b0;
    repeat (3) step();
    chk("rst_cfg",   bus.dcr_cam_cfg_o, 32'h2);
    chk("rst_state", 32'(bus.state_o), 32'd0);
    chk("rst_ready", 32'(bus.cam_ready_o), 32'd0);
    chk("rst_busy",  32'(bus.busy_o), 32'd0);
    chk("rst_done",  32'(bus.done_o), 32'd0);
    rst_n = 1'b1;
    step(); step();

    // Down request in IDLE is ignored.
    pulse(1'b0, 1'b1);
    chk("idle_dn_state", 32'(bus.state_o), 32'd0);
    chk("idle_dn_done",  32'(bus.done_o), 32'd0);

    // Full power-up; pulse in cycle 0.
    pulse(1'b1, 1'b0);                                   // cycle 1
    chk("up_c1_cfg",   bus.dcr_cam_cfg_o, 32'h3);
    chk("up_c1_state", 32'(bus.state_o), 32'd1);
    chk("up_c1_busy",  32'(bus.busy_o), 32'd1);
    repeat (3) step();                                   // cycle 4
    chk("up_c4_cfg", bus.dcr_cam_cfg_o, 32'h3);
    step();                                              // cycle 5
    chk("up_c5_cfg",   bus.dcr_cam_cfg_o, 32'h1);
    chk("up_c5_state", 32'(bus.state_o), 32'd2);
    repeat (7) step();                                   // cycle 12
    chk("up_c12_ready", 32'(bus.cam_ready_o), 32'd0);
    step();                                              // cycle 13
    chk("up_c13_ready", 32'(bus.cam_ready_o), 32'd1);
    chk("up_c13_done",  32'(bus.done_o), 32'd1);
    chk("up_c13_state", 32'(bus.state_o), 32'd3);
    step();
    chk("up_c14_done", 32'(bus.done_o), 32'd0);

    // Up request in READY is ignored.
    pulse(1'b1, 1'b0);
    chk("ready_up_state", 32'(bus.state_o), 32'd3);

    // Shutdown from READY; a second down request mid-shutdown is ignored.
    pulse(1'b0, 1'b1);                                   // cycle 1
    chk("dn_c1_state", 32'(bus.state_o), 32'd4);
    chk("dn_c1_cfg",   bus.dcr_cam_cfg_o, 32'h3);
    chk("dn_c1_busy",  32'(bus.busy_o), 32'd1);
    step();                                              // cycle 2
    pulse(1'b0, 1'b1);                                   // cycle 3
    step();                                              // cycle 4
    chk("dn_c4_cfg",  bus.dcr_cam_cfg_o, 32'h3);
    chk("dn_c4_busy", 32'(bus.busy_o), 32'd1);
    step();                                              // cycle 5
    chk("dn_c5_state", 32'(bus.state_o), 32'd0);
    chk("dn_c5_cfg",   bus.dcr_cam_cfg_o, 32'h2);
    chk("dn_c5_done",  32'(bus.done_o), 32'd1);
    step();
    chk("dn_c6_done", 32'(bus.done_o), 32'd0);

    // Abort in the third SETTLE cycle (cycle 7).
    r0 = ready_cnt;
    pulse(1'b1, 1'b0);                                   // cycle 1
    repeat (6) step();                                   // cycle 7
    chk("ab_c7_state", 32'(bus.state_o), 32'd2);
    pulse(1'b0, 1'b1);                                   // cycle 8
    chk("ab_c8_state", 32'(bus.state_o), 32'd4);
    repeat (3) step();                                   // cycle 11
    chk("ab_c11_state", 32'(bus.state_o), 32'd4);
    step();                                              // cycle 12
    chk("ab_c12_state", 32'(bus.state_o), 32'd0);
    chk("ab_c12_done",  32'(bus.done_o), 32'd1);
    chk("ab_no_ready",  32'(ready_cnt - r0), 32'd0);
    step();

    // Both requests together: no-op in IDLE, shutdown in READY.
    pulse(1'b1, 1'b1);
    chk("both_idle_state", 32'(bus.state_o), 32'd0);
    step();
    chk("both_idle_state2", 32'(bus.state_o), 32'd0);
    pulse(1'b1, 1'b0);
    repeat (12) step();                                  // cycle 13
    chk("both_rdy_pre", 32'(bus.state_o), 32'd3);
    pulse(1'b1, 1'b1);
    chk("both_rdy_state", 32'(bus.state_o), 32'd4);
    repeat (4) step();
    chk("both_rdy_idle", 32'(bus.state_o), 32'd0);

    // Asynchronous reset mid PWDN_HOLD, then a clean restart.
    pulse(1'b1, 1'b0);                                   // cycle 1
    step();                                              // cycle 2
    chk("ar_pre_state", 32'(bus.state_o), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("ar_state", 32'(bus.state_o), 32'd0);
    chk("ar_cfg",   bus.dcr_cam_cfg_o, 32'h2);
    chk("ar_busy",  32'(bus.busy_o), 32'd0);
    step();
    rst_n = 1'b1;
    step();
    pulse(1'b1, 1'b0);                                   // cycle 1
    repeat (11) step();                                  // cycle 12
    chk("ar_c12_ready", 32'(bus.cam_ready_o), 32'd0);
    step();                                              // cycle 13
    chk("ar_c13_ready", 32'(bus.cam_ready_o), 32'd1);
    chk("ar_c13_done",  32'(bus.done_o), 32'd1);

    // Back to IDLE, then power up with extra up pulses in cycles 2, 6 and 10.
    pulse(1'b0, 1'b1);
    repeat (4) step();
    step();
    pulse(1'b1, 1'b0);                                   // cycle 1
    step();                                              // cycle 2
    pulse(1'b1, 1'b0);                                   // cycle 3
    repeat (3) step();                                   // cycle 6
    pulse(1'b1, 1'b0);                                   // cycle 7
    repeat (3) step();                                   // cycle 10
    pulse(1'b1, 1'b0);                                   // cycle 11
    step();                                              // cycle 12
    chk("ex_c12_ready", 32'(bus.cam_ready_o), 32'd0);
    chk("ex_c12_state", 32'(bus.state_o), 32'd2);
    step();                                              // cycle 13
    chk("ex_c13_ready", 32'(bus.cam_ready_o), 32'd1);
    chk("ex_c13_done",  32'(bus.done_o), 32'd1);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dvp_cam_pwr_seq.md
DVP_CAM_PWR_SEQ -- requirements
Module: dvp_cam_pwr_seq

Interface
REQ-001 Parameter DVP_CAM_CFG_W, default 32: width of the camera configuration word driven to the DVP camera controller.
REQ-002 Parameter PWDN_HOLD_CYC, default 125000: clk cycles that XCLK runs with PWDN asserted (1 ms at 125 MHz); legal range ≥1.
REQ-003 Parameter SETTLE_CYC, default 1250000: clk cycles after PWDN release before the camera is declared ready (10 ms at 125 MHz); legal range ≥1.
REQ-004 Port clk, input, 1: the single clock. Reset is asynchronous and active-low.
REQ-005 Port rst_n, input, 1: asynchronous active-low reset.
REQ-006 Port pwr_up_req_i, input, 1: single-cycle power-up request pulse.
REQ-007 Port pwr_dn_req_i, input, 1: single-cycle power-down request pulse.
REQ-008 Port dcr_cam_cfg_o, output, DVP_CAM_CFG_W: configuration word to the camera controller; bit0 = start/XCLK enable, bit1 = PWDN, all other bits 0.
REQ-009 Port cam_ready_o, output, 1: high only in READY.
REQ-010 Port busy_o, output, 1: high in PWDN_HOLD, SETTLE and SHUTDOWN.
REQ-011 Port done_o, output, 1: one-cycle pulse on entry to READY or on return to IDLE from SHUTDOWN.
REQ-012 Port state_o, output, 3: current state encoding for status readback.

Function
REQ-013 States and outputs (start, pwdn): IDLE (0,1); PWDN_HOLD (1,1); SETTLE (1,0); READY (1,0); SHUTDOWN (1,1).
REQ-014 In IDLE, a pwr_up_req_i sampled at edge t moves to PWDN_HOLD at t+1 and loads the timer with PWDN_HOLD_CYC-1.
REQ-015 The timer decrements once per cycle. A timed state transitions on the edge where the timer reads 0, so each timed state lasts exactly its parameter value in cycles.
REQ-016 Transitions: PWDN_HOLD expiry -> SETTLE with timer loaded SETTLE_CYC-1; SETTLE expiry -> READY; SHUTDOWN expiry -> IDLE.
REQ-017 In READY, pwr_dn_req_i moves to SHUTDOWN next cycle with timer loaded PWDN_HOLD_CYC-1.
REQ-018 In PWDN_HOLD or SETTLE, pwr_dn_req_i aborts to SHUTDOWN next cycle, reloads the timer, and produces no READY or done_o for the aborted power-up.
REQ-019 If both requests are high in the same cycle, pwr_dn_req_i wins. In IDLE, that case is treated as no request.
REQ-020 pwr_up_req_i is ignored outside IDLE. pwr_dn_req_i is ignored in IDLE and SHUTDOWN.
REQ-021 Outputs are registered or decoded directly from registered state: state entry at edge t drives new dcr_cam_cfg_o, cam_ready_o and busy_o in cycle t.
REQ-022 done_o is high in the first cycle of READY, or the first cycle of IDLE after SHUTDOWN; it is never high after reset.
REQ-023 Timer width = $clog2(max(PWDN_HOLD_CYC, SETTLE_CYC)+1). The timer never wraps; it holds 0 in untimed states.

Reset
REQ-024 Asserting rst_n low at any time, including mid-sequence, forces IDLE and timer 0 asynchronously.
REQ-025 During and after reset: dcr_cam_cfg_o = 0x00000002 (PWDN=1, start=0), cam_ready_o = 0, busy_o = 0, done_o = 0, state_o = IDLE.

Structure
REQ-026 Package dvp_cam_pkg holds the state encoding (IDLE=0, PWDN_HOLD=1, SETTLE=2, READY=3, SHUTDOWN=4) and the config bit indices (CFG_START_BIT=0, CFG_PWDN_BIT=1). The DVP camera controller shares these indices.
REQ-027 One sub-module, dvp_seq_timer, provides the loadable down-counter with a zero flag. The FSM stays in dvp_cam_pwr_seq.

Verification (PWDN_HOLD_CYC=4, SETTLE_CYC=8)
REQ-028 Reset release then up pulse at cycle 0: cfg=0x3 for cycles 1-4, cfg=0x1 from cycle 5, cam_ready_o=1 and done_o pulse at cycle 13.
REQ-029 From READY, down pulse at cycle 0: cfg=0x3 and busy_o=1 for cycles 1-4, IDLE with cfg=0x2 and done_o pulse at cycle 5.
REQ-030 Down pulse in SETTLE third cycle: SHUTDOWN next cycle, cam_ready_o never 1, IDLE 4 cycles later.
REQ-031 Up and down high together in IDLE: state stays IDLE. Same pair in READY: SHUTDOWN entered.
REQ-032 rst_n low mid-PWDN_HOLD: cfg=0x2 and state IDLE immediately, without waiting for a clock edge; a fresh up pulse restarts the full 4+8 sequence.
REQ-033 Extra up pulses during PWDN_HOLD and SETTLE: timing is unchanged and READY is still reached at cycle 13.
